// File: rtl/tile_mac_engine_pkg.sv
// Shared types and defaults for the systolic tile MAC engine.
package tile_mac_engine_pkg;
    localparam int DEF_DIM    = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_OUT_W  = 8;
    localparam int DEF_K_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
endpackage

// File: rtl/tile_mac_engine_pe.sv
// One processing element: registered operand pass-through plus signed MAC.
module mac_pe
    import tile_mac_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic signed [DATA_W-1:0] b_out,
    output logic signed [ACC_W-1:0]  acc
);
    logic signed [DATA_W-1:0]   a_reg, b_reg;
    logic signed [ACC_W-1:0]    acc_reg;
    logic signed [2*DATA_W-1:0] prod;

    assign prod = a_in * b_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
        end else if (clr) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
        end else if (en) begin
            a_reg   <= a_in;
            b_reg   <= b_in;
            acc_reg <= acc_reg + ACC_W'(prod);
        end
    end

    assign a_out = a_reg;
    assign b_out = b_reg;
    assign acc   = acc_reg;
endmodule

// File: rtl/tile_mac_engine.sv
// Output-stationary DIM x DIM systolic MAC tile with stallable operand feed
// and a backpressured, lane-masked row drain with saturate/wrap conversion.
module tile_mac_engine
    import tile_mac_engine_pkg::*;
#(
    parameter int DIM    = DEF_DIM,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int K_W    = DEF_K_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [K_W-1:0]          k_i,
    input  logic [$clog2(DIM):0]    rows_i,
    input  logic [$clog2(DIM):0]    cols_i,
    input  logic                    sat_i,
    output logic                    busy_o,
    output logic                    done_o,
    input  logic                    opd_valid_i,
    output logic                    opd_ready_o,
    input  logic [DIM*DATA_W-1:0]   a_word_i,
    input  logic [DIM*DATA_W-1:0]   b_word_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [$clog2(DIM)-1:0]  res_row_o,
    output logic [DIM*OUT_W-1:0]    res_word_o,
    output logic [DIM-1:0]          res_mask_o
);
    localparam int ROW_W = $clog2(DIM);
    localparam int CNT_W = ROW_W + 1;
    localparam int FL_W  = $clog2(2*DIM);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(2*DIM-2);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    state_t             state_reg;
    logic               busy_reg, done_reg, ready_reg, valid_reg, sat_reg;
    logic [K_W-1:0]     k_reg, k_cnt_reg;
    logic [FL_W-1:0]    fl_cnt_reg;
    logic [CNT_W-1:0]   rows_reg, cols_reg, rows_clamp, cols_clamp;
    logic [ROW_W-1:0]   row_reg, load_row;
    logic [DIM*OUT_W-1:0] word_reg, conv_word;
    logic [DIM-1:0]     mask_reg, conv_mask;
    logic               step, clr;

    logic signed [DATA_W-1:0] a_skew [DIM];
    logic signed [DATA_W-1:0] b_skew [DIM];
    logic signed [DATA_W-1:0] a_pass [DIM][DIM];
    logic signed [DATA_W-1:0] b_pass [DIM][DIM];
    logic signed [ACC_W-1:0]  acc_w  [DIM][DIM];

    assign clr  = (state_reg == ST_IDLE) && start_i;
    // Bubbles in FEED freeze skew, array and counter alike.
    assign step = ((state_reg == ST_FEED) && opd_valid_i) || (state_reg == ST_FLUSH);

    assign rows_clamp = (rows_i > CNT_W'(DIM)) ? CNT_W'(DIM) : rows_i;
    assign cols_clamp = (cols_i > CNT_W'(DIM)) ? CNT_W'(DIM) : cols_i;

    // Input skew: lane gi is delayed gi steps; FLUSH injects zeros.
    for (genvar gi = 0; gi < DIM; gi++) begin : g_skew
        logic signed [DATA_W-1:0] a_lane, b_lane;
        assign a_lane = (state_reg == ST_FEED) ? a_word_i[gi*DATA_W +: DATA_W] : '0;
        assign b_lane = (state_reg == ST_FEED) ? b_word_i[gi*DATA_W +: DATA_W] : '0;
        if (gi == 0) begin : g_direct
            assign a_skew[gi] = a_lane;
            assign b_skew[gi] = b_lane;
        end else begin : g_delay
            logic signed [DATA_W-1:0] a_dl [gi];
            logic signed [DATA_W-1:0] b_dl [gi];
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i || clr) begin
                    for (int d = 0; d < gi; d++) begin
                        a_dl[d] <= '0;
                        b_dl[d] <= '0;
                    end
                end else if (step) begin
                    a_dl[0] <= a_lane;
                    b_dl[0] <= b_lane;
                    for (int d = 1; d < gi; d++) begin
                        a_dl[d] <= a_dl[d-1];
                        b_dl[d] <= b_dl[d-1];
                    end
                end
            end
            assign a_skew[gi] = a_dl[gi-1];
            assign b_skew[gi] = b_dl[gi-1];
        end
    end

    for (genvar gi = 0; gi < DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < DIM; gj++) begin : g_col
            logic signed [DATA_W-1:0] a_in, b_in;
            if (gj == 0) begin : g_a0
                assign a_in = a_skew[gi];
            end else begin : g_an
                assign a_in = a_pass[gi][gj-1];
            end
            if (gi == 0) begin : g_b0
                assign b_in = b_skew[gj];
            end else begin : g_bn
                assign b_in = b_pass[gi-1][gj];
            end
            mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk   (clk_i),
                .rst   (rst_i),
                .clr   (clr),
                .en    (step),
                .a_in  (a_in),
                .b_in  (b_in),
                .a_out (a_pass[gi][gj]),
                .b_out (b_pass[gi][gj]),
                .acc   (acc_w[gi][gj])
            );
        end
    end

    // The first DRAIN cycle loads row 0; each later handshake preloads the next row.
    assign load_row = valid_reg ? row_reg + 1'b1 : row_reg;

    for (genvar gj = 0; gj < DIM; gj++) begin : g_conv
        logic signed [ACC_W-1:0] v;
        logic [OUT_W-1:0]        c;
        assign v = acc_w[load_row][gj];
        always_comb begin
            c = '0;
            if (CNT_W'(gj) < cols_reg) begin
                if (sat_reg == MODE_SAT) begin
                    if (v > SAT_MAX)      c = SAT_MAX[OUT_W-1:0];
                    else if (v < SAT_MIN) c = SAT_MIN[OUT_W-1:0];
                    else                  c = v[OUT_W-1:0];
                end else begin
                    c = v[OUT_W-1:0];
                end
            end
        end
        assign conv_word[gj*OUT_W +: OUT_W] = c;
        assign conv_mask[gj] = (CNT_W'(gj) < cols_reg);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            ready_reg  <= 1'b0;
            valid_reg  <= 1'b0;
            sat_reg    <= MODE_WRAP;
            k_reg      <= '0;
            k_cnt_reg  <= '0;
            fl_cnt_reg <= '0;
            rows_reg   <= '0;
            cols_reg   <= '0;
            row_reg    <= '0;
            word_reg   <= '0;
            mask_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_i) begin
                        k_reg      <= k_i;
                        rows_reg   <= rows_clamp;
                        cols_reg   <= cols_clamp;
                        sat_reg    <= sat_i;
                        k_cnt_reg  <= '0;
                        fl_cnt_reg <= '0;
                        row_reg    <= '0;
                        busy_reg   <= 1'b1;
                        if (k_i == '0) begin
                            state_reg <= ST_FLUSH;
                        end else begin
                            state_reg <= ST_FEED;
                            ready_reg <= 1'b1;
                        end
                    end
                end
                ST_FEED: begin
                    if (opd_valid_i) begin
                        k_cnt_reg <= k_cnt_reg + 1'b1;
                        if (k_cnt_reg == k_reg - 1'b1) begin
                            state_reg <= ST_FLUSH;
                            ready_reg <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    fl_cnt_reg <= fl_cnt_reg + 1'b1;
                    if (fl_cnt_reg == FL_LAST) begin
                        if (rows_reg == '0) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!valid_reg) begin
                        valid_reg <= 1'b1;
                        word_reg  <= conv_word;
                        mask_reg  <= conv_mask;
                    end else if (res_ready_i) begin
                        if ({1'b0, row_reg} == rows_reg - 1'b1) begin
                            state_reg <= ST_IDLE;
                            valid_reg <= 1'b0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            row_reg  <= row_reg + 1'b1;
                            word_reg <= conv_word;
                            mask_reg <= conv_mask;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = busy_reg;
    assign done_o      = done_reg;
    assign opd_ready_o = ready_reg;
    assign res_valid_o = valid_reg;
    assign res_row_o   = row_reg;
    assign res_word_o  = word_reg;
    assign res_mask_o  = mask_reg;
endmodule

// File: tb/tb_tile_mac_engine.sv
// Directed table-driven bench for tile_mac_engine at DIM=4.
module tb_tile_mac_engine;
    localparam int DIM = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] k_i = '0;
    logic [2:0]  rows_i = '0, cols_i = '0;
    logic        sat_i = 1'b0;
    logic        busy_o, done_o;
    logic        opd_valid_i = 1'b0;
    logic        opd_ready_o;
    logic [31:0] a_word_i = '0, b_word_i = '0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b1;
    logic [1:0]  res_row_o;
    logic [31:0] res_word_o;
    logic [3:0]  res_mask_o;

    tile_mac_engine #(.DIM(DIM), .DATA_W(8), .ACC_W(32), .OUT_W(8), .K_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .k_i(k_i),
        .rows_i(rows_i), .cols_i(cols_i), .sat_i(sat_i),
        .busy_o(busy_o), .done_o(done_o),
        .opd_valid_i(opd_valid_i), .opd_ready_o(opd_ready_o),
        .a_word_i(a_word_i), .b_word_i(b_word_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_row_o(res_row_o), .res_word_o(res_word_o), .res_mask_o(res_mask_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              k;
        logic [2:0]      rows, cols;
        logic            sat;
        bit              stall, bp;
        logic [3:0][31:0] a_w, b_w, exp_w;
        logic [3:0]      exp_mask;
        int              exp_rows;
    } vec_t;

    vec_t tv [11];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] mk(input int x0, input int x1, input int x2, input int x3);
        return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input int v);
        vec_t t;
        int t0, got, g;
        bit done_seen, first;
        t = tv[v];
        k_i = 16'(t.k); rows_i = t.rows; cols_i = t.cols; sat_i = t.sat;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        t0 = cyc;
        chk("busy_after_start", 64'(busy_o), 64'd1);
        for (int s = 0; s < t.k; s++) begin
            opd_valid_i = 1'b1; a_word_i = t.a_w[s]; b_word_i = t.b_w[s];
            g = 0;
            while (!opd_ready_o && g < 20) begin @(posedge clk); #1; g++; end
            chk("feed_ready", 64'(opd_ready_o), 64'd1);
            @(posedge clk); #1;
            if (t.stall) begin
                opd_valid_i = 1'b0; a_word_i = 32'hDEADBEEF; b_word_i = 32'h5A5A5A5A;
                start_i = 1'b1; k_i = 16'd1;
                @(posedge clk); #1;
                start_i = 1'b0;
                chk("busy_during_stall", 64'(busy_o), 64'd1);
            end
        end
        opd_valid_i = 1'b0; a_word_i = '0; b_word_i = '0;
        got = 0; done_seen = 0; first = 1;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            @(posedge clk); #1;
            if (done_o) begin
                done_seen = 1;
                chk("busy_at_done", 64'(busy_o), 64'd0);
                chk("valid_at_done", 64'(res_valid_o), 64'd0);
                chk("row_count", 64'(got), 64'(t.exp_rows));
            end else if (res_valid_o) begin
                if (first) begin
                    first = 0;
                    if (!t.stall) chk("first_valid_cycle", 64'(cyc - t0), 64'(t.k + 2*DIM));
                end
                chk("row_idx", 64'(res_row_o), 64'(got));
                if (got < 4) chk("row_word", 64'(res_word_o), 64'(t.exp_w[got]));
                chk("row_mask", 64'(res_mask_o), 64'(t.exp_mask));
                if (t.bp && got == 1) begin
                    res_ready_i = 1'b0;
                    repeat (5) begin
                        @(posedge clk); #1;
                        chk("bp_valid", 64'(res_valid_o), 64'd1);
                        chk("bp_row", 64'(res_row_o), 64'd1);
                        chk("bp_word", 64'(res_word_o), 64'(t.exp_w[1]));
                    end
                    res_ready_i = 1'b1;
                end
                got++;
            end
        end
        if (!done_seen) chk("done_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        chk("done_single_pulse", 64'(done_o), 64'd0);
        $display("vector %0d: k=%0d rows=%0d cols=%0d sat=%0d rows_seen=%0d", v, t.k, t.rows, t.cols, t.sat, got);
    endtask

    initial begin
        // Identity A with B rows 1..16 reproduces B.
        tv[0].k = 4; tv[0].rows = 3'd4; tv[0].cols = 3'd4; tv[0].sat = 1'b1;
        tv[0].stall = 0; tv[0].bp = 0; tv[0].exp_mask = 4'hF; tv[0].exp_rows = 4;
        for (int s = 0; s < 4; s++) begin
            tv[0].a_w[s] = 32'd1 << (8*s);
            tv[0].b_w[s] = mk(4*s+1, 4*s+2, 4*s+3, 4*s+4);
            tv[0].exp_w[s] = tv[0].b_w[s];
        end
        for (int v = 1; v < 11; v++) tv[v] = tv[0];
        // 127*127*4 = 64516: saturates to 127, wraps to 4.
        for (int s = 0; s < 4; s++) begin
            tv[1].a_w[s] = mk(127, 127, 127, 127); tv[1].b_w[s] = mk(127, 127, 127, 127);
            tv[1].exp_w[s] = 32'h7F7F7F7F;
        end
        tv[2] = tv[1]; tv[2].sat = 1'b0;
        for (int s = 0; s < 4; s++) tv[2].exp_w[s] = 32'h04040404;
        // -128*127*4 = -65024: saturates to -128, wraps to 0.
        for (int s = 0; s < 4; s++) begin
            tv[3].a_w[s] = mk(-128, -128, -128, -128); tv[3].b_w[s] = mk(127, 127, 127, 127);
            tv[3].exp_w[s] = 32'h80808080;
        end
        tv[4] = tv[3]; tv[4].sat = 1'b0;
        for (int s = 0; s < 4; s++) tv[4].exp_w[s] = 32'h00000000;
        // Partial tile: 2 rows, 3 lanes, K=3 of ones.
        tv[5].k = 3; tv[5].rows = 3'd2; tv[5].cols = 3'd3; tv[5].exp_mask = 4'b0111; tv[5].exp_rows = 2;
        for (int s = 0; s < 4; s++) begin
            tv[5].a_w[s] = mk(1, 1, 1, 1); tv[5].b_w[s] = mk(1, 1, 1, 1);
            tv[5].exp_w[s] = mk(3, 3, 3, 0);
        end
        tv[6].stall = 1;
        tv[7].bp = 1;
        tv[8].k = 0;
        for (int s = 0; s < 4; s++) tv[8].exp_w[s] = 32'h0;
        tv[9].rows = 3'd7; tv[9].cols = 3'd6;
        tv[10].rows = 3'd0; tv[10].exp_rows = 0;

        #12;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_opd_ready", 64'(opd_ready_o), 64'd0);
        chk("rst_res_valid", 64'(res_valid_o), 64'd0);
        chk("rst_res_row", 64'(res_row_o), 64'd0);
        chk("rst_res_word", 64'(res_word_o), 64'd0);
        chk("rst_res_mask", 64'(res_mask_o), 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 11; v++) run_vec(v);

        // Reset after two handshakes of an identity run.
        k_i = 16'd4; rows_i = 3'd4; cols_i = 3'd4; sat_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int s = 0; s < 2; s++) begin
            opd_valid_i = 1'b1; a_word_i = tv[0].a_w[s]; b_word_i = tv[0].b_w[s];
            @(posedge clk); #1;
        end
        rst_i = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_opd_ready", 64'(opd_ready_o), 64'd0);
        chk("midrst_res_valid", 64'(res_valid_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        opd_valid_i = 1'b0; a_word_i = '0; b_word_i = '0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        $display("mid-FEED reset applied, rerunning identity");
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tile_mac_engine.md
Name: tile_mac_engine

Overview:
- Parametrised successor of the fixed 8x8 TPU datapath: a DIM x DIM output-stationary systolic tile engine with generic operand, accumulator and output widths.
- Operand columns of A and rows of B arrive over a stallable valid/ready stream.
- Internal skew, MAC array and flush sequencing are self-contained.
- Results are drained row by row over a backpressured valid/ready port with lane mask and selectable saturate/wrap conversion. This replaces the combinational column mux plus external write-enable scheme.

Parameters:
- DIM, 8, array rows = columns = lanes per word.
- DATA_W, 8, signed operand lane width.
- ACC_W, 32, signed accumulator width.
- OUT_W, 8, signed result lane width.
- K_W, 16, width of the reduction-length input.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  start pulse; accepted only in IDLE.
- k_i  in  K_W  reduction length K; sampled on start.
- rows_i  in  $clog2(DIM)+1  valid result rows; sampled on start; values >DIM clamp to DIM.
- cols_i  in  $clog2(DIM)+1  valid result lanes; sampled on start; values >DIM clamp to DIM.
- sat_i  in  1  1 = saturate, 0 = wrap; sampled on start.
- busy_o  out  1  high from start acceptance until done.
- done_o  out  1  one-cycle completion pulse.
- opd_valid_i  in  1  operand pair valid.
- opd_ready_o  out  1  high only in FEED.
- a_word_i  in  DIM*DATA_W  column k of A; lane i = row i.
- b_word_i  in  DIM*DATA_W  row k of B; lane j = column j.
- res_valid_o  out  1  result row valid.
- res_ready_i  in  1  result row accepted.
- res_row_o  out  $clog2(DIM)  row index of current result.
- res_word_o  out  DIM*OUT_W  converted row; lane j = C[row][j].
- res_mask_o  out  DIM  lane j enabled iff j<cols.

Behaviour:
- Reset (async, any state): FSM to IDLE. busy_o, done_o, opd_ready_o and res_valid_o are 0; res_row_o, res_word_o and res_mask_o are 0; all accumulators, skew and pipeline registers are 0.
- FSM states: IDLE, FEED, FLUSH, DRAIN.
- IDLE: on start_i, latch parameters, clear all accumulators and skew registers, and go to FEED (or to FLUSH if K=0). start_i in any other state is ignored.
- FEED: opd_ready_o=1. Each handshake (opd_valid_i&opd_ready_o) is one array step. No handshake means the whole array, skew and k counter hold (bubbles are transparent). After the K-th handshake, go to FLUSH.
- Array step:
  - A lane i is delayed i steps before entering PE(i,0); B lane j is delayed j steps before entering PE(0,j).
  - Operands shift right (A) and down (B) one PE per step.
  - Each PE does acc += a*b as a signed DATA_W x DATA_W product, sign-extended to ACC_W, wrapping at ACC_W.
- FLUSH: steps every cycle with zero operands injected, for exactly 2*DIM-1 cycles. Then go to DRAIN, or go to IDLE with done_o pulse if rows=0.
- DRAIN:
  - Emit rows 0..rows-1 in ascending order; res_valid_o=1.
  - Outputs are stable while res_valid_o&!res_ready_i.
  - The row advances on handshake. After the handshake of the last row: IDLE, done_o=1 for one cycle, busy_o drops the same cycle.
- Conversion per lane:
  - sat_i=1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat_i=0: low OUT_W bits of the accumulator.
  - Lanes j>=cols are driven 0; res_mask_o[j]=(j<cols).
- res_word_o is registered; nothing combinational flows from res_ready_i to res_word_o.
- Latency with no stalls: start accepted at edge 0; FEED K cycles; FLUSH 2*DIM-1; first res_valid_o at cycle K+2*DIM; done_o after rows further handshakes.
- Accumulators persist after done and are cleared only on the next start.

Decomposition:
- def.v gains: FSM state encodings (2-bit), SAT/WRAP mode constants, and the defaults for DIM/DATA_W/ACC_W/OUT_W.
- One sub-module: mac_pe, holding the a/b pass-through registers, the step enable, the clear and the signed MAC accumulator.
- The skew, FSM, counters and drain/convert logic live in tile_mac_engine, with the array built by a generate loop.

Test Plan (DIM=4, DATA_W=8, OUT_W=8, ACC_W=32):
- Identity: K=4, A=I, B rows {1..4},{5..8},{9..12},{13..16}, sat=1, rows=cols=4 -> rows 0..3 equal B rows, mask 4'hF, first res_valid_o at cycle 12, single done_o.
- Saturate/wrap:
  - K=4, all a=127, b=127 (acc 64516) -> sat=1: every lane 127; sat=0: every lane 4.
  - a=-128, b=127 (acc -65024) -> sat=1: lane value -128 (8'h80); sat=0: 0.
- Backpressure: identity case with res_ready_i=0 for 5 cycles while row 1 is valid -> row 1 word held stable; order 0,1,2,3; exactly one done_o.
- Partial tile: rows=2, cols=3, all a=b=1, K=3 -> exactly 2 rows, lanes 0..2 = 3, lane 3 = 0, mask 4'b0111.
- Stalls/ignored events:
  - opd_valid_i alternating 1,0 gives results identical to the identity case.
  - start_i during FEED is ignored.
  - K=0 gives all-zero rows.
- Reset mid-FEED: assert rst_i after 2 handshakes -> busy_o, opd_ready_o, res_valid_o and done_o go 0 immediately; a subsequent identity run gives correct results with no residue.
